fpga_reset_seq: RTL and testbench
=================================

// Module: fpga_reset_seq
// PURPOSE
//  Receiving end of the FPGA reset/start vector produced by the sim/FPGA reset generator.
//  Synchronizes the async reset and start request bits into CLK and sequences release:
//  resets first, then starts after a gap, then staggered delay releases.
//  Sits between the generator and the CSP-derived process instances; drives their reset/start pins.
// PARAMETERS
//  RESETS        1     number of reset request bits (req_n[RESETS-1:0])
//  STARTS        0     number of start request bits (req_n[RESETS+STARTS-1:RESETS])
//  DELAYS        0     number of locally generated, staggered delay releases
//  SYNC_STAGES   2     synchronizer depth per request bit, >=2
//  START_GAP     4     cycles between reset release and start evaluation, >=1
//  DELAY_CYCLES  16    stagger between successive delay releases, >=1
//  WDOG_CYCLES   1024  start watchdog limit (FPGA_RESET_SEQ_WDOG_EN only)
// PORTS
//  CLK       in   1                 clock
//  reset_n   in   1                 asynchronous, active-low global reset
//  req_n     in   RESETS+STARTS     async request bits from generator, 1 = released
//  rst_n_o   out  RESETS            sequenced reset releases
//  start_o   out  max(STARTS,1)     sequenced start releases (tied 0 when STARTS==0)
//  delay_o   out  max(DELAYS,1)     staggered delay releases (tied 0 when DELAYS==0)
//  state_o   out  3                 current sequencer state encoding
//  ready_o   out  1                 1 in RUN only
//  wdog_o    out  1                 start watchdog fired (0 when macro absent)
// BEHAVIOUR
//  - reset_n low: all outputs 0, state IDLE, counters 0, synchronizer flops 0; asserts without CLK.
//  - Each req_n bit passes through SYNC_STAGES flops; s_rst = synced reset bits, s_st = synced start bits.
//  - All outputs are registered, decoded from next state.
//  - IDLE: outputs 0. Go to GAP when &s_rst==1. Partial reset set stays in IDLE.
//  - GAP: rst_n_o='1; load START_GAP on entry, decrement, go WAIT_START at count 0.
//  - WAIT_START: go START when &s_st==1; STARTS==0 passes through in one cycle.
//  - START: start_o='1; one cycle, then DELAY, delay counter cleared.
//  - DELAY: counter increments; delay_o[i] rises at count DELAY_CYCLES*(i+1), stays high.
//    Go RUN in the same cycle delay_o[DELAYS-1] rises; DELAYS==0 -> RUN directly.
//  - RUN: ready_o=1, all outputs held.
//  - Latency: req reset bits rise -> rst_n_o high at edge SYNC_STAGES+1.
//    Same rule for start bits -> start_o once in WAIT_START.
//  - Abort: any s_rst bit 0 in a non-IDLE state -> IDLE next cycle, all outputs 0.
//  - Start drop: any s_st bit 0 in START/DELAY/RUN -> WAIT_START next cycle;
//    start_o, delay_o and ready_o cleared; rst_n_o stays 1.
//  - Abort has priority over start drop when both occur in the same cycle.
//  - Counters are saturating and sized with $clog2 of max count + 1; no wrap.
// CONFIGURATION
//  FPGA_RESET_SEQ_WDOG_EN defined:
//    - Counter runs while in WAIT_START; wdog_o=1 after WDOG_CYCLES consecutive cycles there.
//    - wdog_o is sticky until reset_n low or IDLE; sequencing is unaffected.
//  FPGA_RESET_SEQ_WDOG_EN undefined: no counter, wdog_o tied 0.
// STRUCTURE
//  - fpga_reset_pkg holds:
//      state typedef enum logic [2:0] {IDLE,GAP,WAIT_START,START,DELAY,RUN};
//      width helper functions; state_o encoding constants.
//  - Sub-module fpga_reset_sync: N-bit, SYNC_STAGES-deep synchronizer, async clear.
//    Instantiated once over the full req_n vector.
// TESTING (RESETS=2 STARTS=1 DELAYS=2 SYNC_STAGES=2 START_GAP=4 DELAY_CYCLES=3)
//  1. req_n=3'b011, start bit held 0
//     -> rst_n_o=2'b11 at edge 3, state WAIT_START, start_o=0 indefinitely.
//  2. Then start bit rises
//     -> start_o=1 at edge 3 after; delay_o=2'b01 3 cycles later;
//        delay_o=2'b11 and ready_o=1 6 cycles after start_o.
//  3. req_n=3'b001 only -> stays IDLE, all outputs 0 for 100 cycles.
//  4. In RUN, req_n[1] falls -> all outputs 0 by edge 3; re-raising it restarts at GAP.
//  5. reset_n pulled low mid-DELAY between edges -> all outputs 0 before next CLK edge.
//  6. Macro on, WDOG_CYCLES=8, start never arrives -> wdog_o=1 8 cycles after WAIT_START entry;
//     stays 1 until reset_n low.

Source files
------------

// File: rtl/fpga_reset_pkg.sv
// rtl/fpga_reset_pkg.sv - shared state encoding and width helpers for the reset sequencer
package fpga_reset_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GAP        = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_START      = 3'd3;
  localparam logic [2:0] ST_DELAY      = 3'd4;
  localparam logic [2:0] ST_RUN        = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    GAP        = ST_GAP,
    WAIT_START = ST_WAIT_START,
    START      = ST_START,
    DELAY      = ST_DELAY,
    RUN        = ST_RUN
  } state_t;

  // Bits needed to hold 0..max_count; never narrower than one bit.
  function automatic int cnt_w(input int max_count);
    if (max_count < 1) return 1;
    return $clog2(max_count + 1);
  endfunction

  // Port width for an optional vector that collapses to a single tied bit.
  function automatic int vec_w(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/fpga_reset_sync.sv
// rtl/fpga_reset_sync.sv - N-bit multi-stage synchronizer with asynchronous clear
module fpga_reset_sync #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         CLK,
  input  logic         reset_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [STAGES-1:0][N-1:0] ff;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/fpga_reset_seq.sv
// rtl/fpga_reset_seq.sv - sequences reset, start and staggered delay releases from the generator vector
// Optional start watchdog: define FPGA_RESET_SEQ_WDOG_EN.
module fpga_reset_seq
  import fpga_reset_pkg::*;
#(
  parameter int RESETS       = 1,
  parameter int STARTS       = 0,
  parameter int DELAYS       = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int START_GAP    = 4,
  parameter int DELAY_CYCLES = 16,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic                       CLK,
  input  logic                       reset_n,
  input  logic [RESETS+STARTS-1:0]   req_n,
  output logic [RESETS-1:0]          rst_n_o,
  output logic [vec_w(STARTS)-1:0]   start_o,
  output logic [vec_w(DELAYS)-1:0]   delay_o,
  output logic [2:0]                 state_o,
  output logic                       ready_o,
  output logic                       wdog_o
);

  localparam int NREQ  = RESETS + STARTS;
  localparam int SW    = vec_w(STARTS);
  localparam int DW    = vec_w(DELAYS);
  localparam int GW    = cnt_w(START_GAP);
  localparam int DMAX  = DELAY_CYCLES * DELAYS;
  localparam int DCW   = cnt_w(DMAX);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(START_GAP);
  localparam logic [DCW-1:0] DCNT_MAX = DCW'(DMAX);

  logic [NREQ-1:0] s_req;
  logic            rst_ok;
  logic            st_ok;
  state_t          state, state_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [DCW-1:0]  dcnt, dcnt_nxt;
  logic [DW-1:0]   delay_nxt;
  logic            started_nxt;

  fpga_reset_sync #(.N(NREQ), .STAGES(SYNC_STAGES)) u_sync (
    .CLK     (CLK),
    .reset_n (reset_n),
    .d       (req_n),
    .q       (s_req)
  );

  assign rst_ok = &s_req[RESETS-1:0];

  generate
    if (STARTS > 0) begin : g_starts
      assign st_ok = &s_req[NREQ-1:RESETS];
    end else begin : g_no_starts
      assign st_ok = 1'b1;
    end
  endgenerate

  // Abort outranks start drop; both outrank normal progression.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    dcnt_nxt  = dcnt;
    if (state != IDLE && !rst_ok) begin
      state_nxt = IDLE;
    end else if ((state == START || state == DELAY || state == RUN) && !st_ok) begin
      state_nxt = WAIT_START;
    end else begin
      case (state)
        IDLE: begin
          if (rst_ok) begin
            state_nxt = GAP;
            gap_nxt   = GAP_LOAD;
          end
        end
        GAP: begin
          gap_nxt = (gap_cnt != '0) ? gap_cnt - 1'b1 : '0;
          if (gap_nxt == '0) state_nxt = WAIT_START;
        end
        WAIT_START: begin
          if (st_ok) begin
            state_nxt = START;
            dcnt_nxt  = '0;
          end
        end
        START, DELAY: begin
          dcnt_nxt  = (dcnt == DCNT_MAX) ? dcnt : dcnt + 1'b1;
          state_nxt = (dcnt_nxt >= DCNT_MAX) ? RUN : DELAY;
        end
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    started_nxt = (state_nxt == START) || (state_nxt == DELAY) || (state_nxt == RUN);
    delay_nxt   = '0;
    for (int i = 0; i < DELAYS; i++) begin
      delay_nxt[i] = (state_nxt == DELAY || state_nxt == RUN) &&
                     (int'(dcnt_nxt) >= DELAY_CYCLES * (i + 1));
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      dcnt    <= '0;
      rst_n_o <= '0;
      start_o <= '0;
      delay_o <= '0;
      ready_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      dcnt    <= dcnt_nxt;
      rst_n_o <= {RESETS{state_nxt != IDLE}};
      start_o <= {SW{(STARTS > 0) && started_nxt}};
      delay_o <= delay_nxt;
      ready_o <= (state_nxt == RUN);
    end
  end

  assign state_o = state;

`ifdef FPGA_RESET_SEQ_WDOG_EN
  localparam int WCW = cnt_w(WDOG_CYCLES);
  localparam logic [WCW-1:0] WCNT_MAX = WCW'(WDOG_CYCLES);

  logic [WCW-1:0] wcnt, wcnt_nxt;

  // Counts only uninterrupted residency in WAIT_START.
  always_comb begin
    wcnt_nxt = '0;
    if (state == WAIT_START && state_nxt == WAIT_START) begin
      wcnt_nxt = (wcnt == WCNT_MAX) ? wcnt : wcnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wcnt   <= '0;
      wdog_o <= 1'b0;
    end else begin
      wcnt   <= wcnt_nxt;
      wdog_o <= (state_nxt != IDLE) && (wdog_o || (wcnt_nxt == WCNT_MAX));
    end
  end
`else
  assign wdog_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_reset_seq.sv
// tb/tb_fpga_reset_seq.sv - randomized model-checked bench for fpga_reset_seq
module tb_fpga_reset_seq;

  localparam int NRS  = 2;
  localparam int NST  = 1;
  localparam int NDL  = 2;
  localparam int SYN  = 2;
  localparam int GAPC = 4;
  localparam int DCY  = 3;
  localparam int WDC  = 8;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] req_n = 3'b000;
  logic [1:0] rst_n_o;
  logic [0:0] start_o;
  logic [1:0] delay_o;
  logic [2:0] state_o;
  logic       ready_o;
  logic       wdog_o;

  int n_checks = 0;
  int n_fail   = 0;

  fpga_reset_seq #(
    .RESETS(NRS), .STARTS(NST), .DELAYS(NDL), .SYNC_STAGES(SYN),
    .START_GAP(GAPC), .DELAY_CYCLES(DCY), .WDOG_CYCLES(WDC)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .req_n(req_n), .rst_n_o(rst_n_o),
    .start_o(start_o), .delay_o(delay_o), .state_o(state_o),
    .ready_o(ready_o), .wdog_o(wdog_o)
  );

  always #5 CLK = ~CLK;

  // Model: up = edges since reset release, st = edges since start release,
  // ws = consecutive edges spent waiting for start; hist = request samples in flight.
  int         up = 0, st = 0, ws = 0;
  bit         wdg = 1'b0;
  logic [2:0] hist [SYN];
  logic [2:0] s;
  bit         was_wait, now_wait;

  initial for (int k = 0; k < SYN; k++) hist[k] = 3'b000;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      up = 0; st = 0; ws = 0; wdg = 1'b0;
      for (int k = 0; k < SYN; k++) hist[k] = 3'b000;
    end else begin
      s = hist[SYN-1];
      for (int k = SYN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = req_n;
      was_wait = (up > GAPC) && (st == 0);
      if (s[1:0] != 2'b11) begin
        up = 0; st = 0;
      end else begin
        if (up < 100000) up++;
        if (was_wait) begin
          if (s[2]) st = 1;
        end else if (st > 0) begin
          if (!s[2]) st = 0;
          else if (st < 100000) st++;
        end
      end
      now_wait = (up > GAPC) && (st == 0);
      ws = (was_wait && now_wait) ? ws + 1 : 0;
      if (ws >= WDC) wdg = 1'b1;
      if (up == 0) wdg = 1'b0;
    end
  end

  logic [9:0] exp_v, act_v;
  logic       e_ready, e_wdog;
  logic [1:0] e_delay;
  logic [2:0] e_state;

  always @(negedge CLK) begin
    e_ready    = (st > 0) && (st - 1 >= DCY * NDL);
    e_delay[0] = (st > 0) && (st - 1 >= DCY);
    e_delay[1] = (st > 0) && (st - 1 >= 2 * DCY);
    if (up == 0)         e_state = 3'd0;
    else if (up <= GAPC) e_state = 3'd1;
    else if (st == 0)    e_state = 3'd2;
    else if (e_ready)    e_state = 3'd5;
    else if (st == 1)    e_state = 3'd3;
    else                 e_state = 3'd4;
`ifdef FPGA_RESET_SEQ_WDOG_EN
    e_wdog = wdg;
`else
    e_wdog = 1'b0;
`endif
    exp_v = {(up > 0) ? 2'b11 : 2'b00, st > 0, e_delay, e_state, e_ready, e_wdog};
    act_v = {rst_n_o, start_o, delay_o, state_o, ready_o, wdog_o};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: {rst,start,delay,state,ready,wdog} got %b required %b",
               $time, act_v, exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  logic [2:0] v;
  int         hold;

  initial begin
    repeat (2) edge1();
    check("reset_outputs", {22'd0, rst_n_o, start_o, delay_o, state_o, ready_o, wdog_o}, 32'd0);
    reset_n = 1'b1;
    edge1();

    // Resets only: release at edge 3, then park in WAIT_START.
    req_n = 3'b011;
    repeat (2) edge1();
    check("t1_rst_edge2", rst_n_o, 2'b00);
    edge1();
    check("t1_rst_edge3", rst_n_o, 2'b11);
    check("t1_state_gap", state_o, 3'd1);
    repeat (4) edge1();
    check("t1_state_wait", state_o, 3'd2);
    repeat (20) edge1();
    check("t1_start_held0", start_o, 1'b0);

    // Start rises: start_o at edge 3, delays at +3 and +6.
    req_n = 3'b111;
    repeat (2) edge1();
    check("t2_start_edge2", start_o, 1'b0);
    edge1();
    check("t2_start_edge3", start_o, 1'b1);
    check("t2_state_start", state_o, 3'd3);
    repeat (3) edge1();
    check("t2_delay_01", delay_o, 2'b01);
    check("t2_ready_early", ready_o, 1'b0);
    repeat (3) edge1();
    check("t2_delay_11", delay_o, 2'b11);
    check("t2_ready", ready_o, 1'b1);
    check("t2_state_run", state_o, 3'd5);

    // Abort from RUN, then restart at GAP.
    req_n = 3'b101;
    repeat (2) edge1();
    check("t4_rst_still_up", rst_n_o, 2'b11);
    edge1();
    check("t4_all_zero", {25'd0, rst_n_o, start_o, delay_o, ready_o}, 32'd0);
    check("t4_state_idle", state_o, 3'd0);
    req_n = 3'b111;
    repeat (3) edge1();
    check("t4_restart_gap", state_o, 3'd1);
    repeat (4) edge1();
    edge1();
    check("t4_start_again", state_o, 3'd3);
    edge1();
    check("t5_in_delay", state_o, 3'd4);

    // Asynchronous reset between edges.
    #3;
    reset_n = 1'b0;
    #1;
    check("t5_async_clear", {22'd0, rst_n_o, start_o, delay_o, state_o, ready_o, wdog_o}, 32'd0);
    edge1();
    reset_n = 1'b1;

    // Partial reset set never leaves IDLE.
    req_n = 3'b001;
    for (int c = 0; c < 100; c++) begin
      edge1();
      check("t3_partial_idle", {22'd0, rst_n_o, start_o, delay_o, state_o, ready_o, wdog_o}, 32'd0);
    end

`ifdef FPGA_RESET_SEQ_WDOG_EN
    // WAIT_START entered at edge 7; watchdog fires 8 edges later.
    req_n = 3'b011;
    repeat (14) edge1();
    check("t6_wdog_pre", wdog_o, 1'b0);
    edge1();
    check("t6_wdog_fire", wdog_o, 1'b1);
    repeat (20) edge1();
    check("t6_wdog_sticky", wdog_o, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_wdog_clear", wdog_o, 1'b0);
    edge1();
    reset_n = 1'b1;
`endif

    // Random request segments with occasional asynchronous reset pulses.
    for (int seg = 0; seg < 90; seg++) begin
      if ($urandom_range(0, 99) < 60) v = 3'b111;
      else v = 3'($urandom_range(0, 7));
      req_n = v;
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 249) == 0) begin
          #1;
          reset_n = 1'b0;
          #1;
          reset_n = 1'b1;
        end
        edge1();
      end
    end

    edge1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
